agc_alu_seq: RTL and testbench
==============================

Name: agc_alu_seq

Overview:
Multi-cycle operation sequencer that sits directly upstream of the ones-complement add/sub, multiply and divide units and consumes their results.
- Accepts one ALU request per valid/ready handshake and holds the operands in registers that drive the selected unit.
- Waits a per-operation settle latency, then captures the unit outputs.
- Adds overflow and divide-by-zero status and returns a registered response through a second valid/ready handshake.

Parameters:
ADD_LAT, 1, cycles from acceptance to resp_valid for ADD/SUB (>=1)
MUL_LAT, 2, cycles from acceptance to resp_valid for MULT (>=1)
DIV_LAT, 3, cycles from acceptance to resp_valid for DIV (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_op  in  2  00 ADD, 01 SUB, 10 MULT, 11 DIV
req_a  in  30  DIV: numerator; other ops: [14:0] only
req_b  in  15  second operand / denominator
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_hi  out  15  ADD/SUB sum; MULT prod[29:15]; DIV quotient
resp_lo  out  15  ADD/SUB 0; MULT prod[14:0]; DIV remainder
resp_ovf  out  1  ADD/SUB ones-complement overflow
resp_uflow  out  1  MULT/DIV conversion underflow, passed through from the unit
resp_dz  out  1  DIV by +0 or -0
as_x, as_y  out  15  add/sub unit operands
as_sub  out  1  add/sub unit subtract select
as_sum  in  15  add/sub unit result
mu_x, mu_y  out  15  multiplier operands
mu_prod  in  30  multiplier product
mu_uflow  in  1  multiplier underflow
dv_numer  out  30  divider numerator
dv_denom  out  15  divider denominator
dv_quot, dv_remain  in  15  divider results
dv_uflow  in  1  divider underflow

Behaviour:
Clock, reset and state machine
- Single clock clk. rst_n is synchronous and active-low. All state changes on the rising edge of clk.
- Reset, sampled at any edge including mid-operation: state goes to IDLE.
  - All registered outputs go to 0: resp_*, operand registers and therefore as_*/mu_*/dv_*.
  - Any in-flight request is discarded; no response is produced for it.
- States: IDLE, WAIT, DONE.
- req_ready = (state==IDLE). It is 1 in the first cycle after reset.
- resp_valid = (state==DONE).

IDLE
- On req_valid at an edge: load op_r, a_r, b_r.
- If op==DIV and req_b is 15'h0000 or 15'h7FFF: go straight to DONE with resp_dz=1, resp_hi=resp_lo=0, resp_ovf=resp_uflow=0.
- Otherwise: go to WAIT with cnt = LAT(op)-1.

WAIT
- cnt decrements each edge.
- At the edge where cnt==0: capture the unit outputs into the resp registers and go to DONE.
- Net latency: resp_valid is first high exactly LAT(op) cycles after the acceptance cycle.

DONE
- Response registers hold stable while resp_ready=0.
- On resp_ready at an edge: go to IDLE. No request overlap; minimum spacing between requests is LAT+2 cycles.

Unit drive (continuous from registers, stable for the whole WAIT interval)
- as_x=mu_x=a_r[14:0]; as_y=mu_y=dv_denom=b_r; dv_numer=a_r.
- as_sub = (op_r==SUB).

Overflow
- y_eff = SUB ? ~b_r : b_r.
- ovf = (a_r[14]==y_eff[14]) && (as_sum[14]!=a_r[14]).
- resp_ovf is 0 for MULT/DIV.

Result handling
- resp_uflow = mu_uflow for MULT, dv_uflow for DIV, 0 otherwise.
- -0 results are passed through unchanged, unless the optional feature below is enabled.

Optional Feature:
AGC_ALU_ZERO_NORM_EN
- Defined: an ADD/SUB resp_hi equal to 15'h7FFF (-0) is replaced by 15'h0000. resp_ovf is unaffected. MULT/DIV words are never altered.
- Undefined: -0 is returned as produced.

Decomposition:
Package agc_alu_pkg holds:
- WORD_W=15 and DWORD_W=30.
- POS_ZERO=15'h0000 and NEG_ZERO=15'h7FFF.
- typedef enum logic[1:0] alu_op_t {OP_ADD, OP_SUB, OP_MULT, OP_DIV}.
- typedef enum state_t {IDLE, WAIT, DONE}.

One sub-module: agc_alu_lat_cnt, a loadable down-counter with a zero flag, sized to $clog2(max LAT)+1.

Test Plan:
Benches attach the real add/sub, multiply and divide units.
1. ADD a=0x0005 b=0x0003 -> resp_valid exactly 1 cycle after accept; hi=0x0008, lo=0, ovf=0, uflow=0.
2. ADD a=0x3FFF b=0x0001 -> hi=0x4000, ovf=1.
3. SUB a=0x0003 b=0x0003 -> hi=0x7FFF without AGC_ALU_ZERO_NORM_EN, hi=0x0000 with it; ovf=0 in both builds.
4. MULT a=0x7FFE (-1) b=0x0002 -> resp_valid 2 cycles after accept; hi=0x7FFF, lo=0x7FFD, ovf=0; output unaffected by AGC_ALU_ZERO_NORM_EN.
5. DIV req_b=0x7FFF, then req_b=0x0000 -> each: resp_valid the cycle after accept, dz=1, hi=lo=0. Then DIV numer=30'd7, b=0x0002 -> after 3 cycles hi=0x0000, lo=0x0001 (quotient = divider result[29:15], which is 0 for this numerator), dz=0.
6. Hold resp_ready=0 for 5 cycles -> resp_* stable and req_ready=0 throughout. Separately, drive rst_n=0 for one edge during WAIT -> the next cycle shows all outputs 0 and req_ready=1, with no response emitted.

Source files
------------

// File: rtl/agc_alu_pkg.sv
// Shared types and constants for the AGC ALU sequencer: word widths,
// ones-complement zero encodings, opcode and FSM state enums.
package agc_alu_pkg;

  localparam int unsigned WORD_W  = 15;
  localparam int unsigned DWORD_W = 30;

  localparam logic [WORD_W-1:0] POS_ZERO = 15'h0000;
  localparam logic [WORD_W-1:0] NEG_ZERO = 15'h7FFF;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MULT, OP_DIV} alu_op_t;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // Ones-complement has two zeros; either one makes a divisor illegal.
  function automatic logic is_zero(input logic [WORD_W-1:0] w);
    return (w == POS_ZERO) || (w == NEG_ZERO);
  endfunction

endpackage

// File: rtl/agc_alu_seq_if.sv
// Request/response handshake bundle between a requester (master) and
// the ALU sequencer (slave).
interface agc_alu_seq_if;
  import agc_alu_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  alu_op_t              req_op;
  logic [DWORD_W-1:0]   req_a;
  logic [WORD_W-1:0]    req_b;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [WORD_W-1:0]    resp_hi;
  logic [WORD_W-1:0]    resp_lo;
  logic                 resp_ovf;
  logic                 resp_uflow;
  logic                 resp_dz;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_hi, resp_lo, resp_ovf, resp_uflow, resp_dz
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_hi, resp_lo, resp_ovf, resp_uflow, resp_dz
  );

endinterface

// File: rtl/agc_alu_lat_cnt.sv
// Loadable down-counter with a zero flag; times the settle interval of the
// attached arithmetic unit.
module agc_alu_lat_cnt #(
  parameter int unsigned Width = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/agc_alu_seq.sv
// Multi-cycle sequencer for the ones-complement add/sub, multiply and divide
// units. Optional macro AGC_ALU_ZERO_NORM_EN folds ADD/SUB -0 results to +0.
module agc_alu_seq
  import agc_alu_pkg::*;
#(
  parameter int unsigned ADD_LAT = 1,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  agc_alu_seq_if.slave       bus,
  output logic [WORD_W-1:0]  as_x,
  output logic [WORD_W-1:0]  as_y,
  output logic               as_sub,
  input  logic [WORD_W-1:0]  as_sum,
  output logic [WORD_W-1:0]  mu_x,
  output logic [WORD_W-1:0]  mu_y,
  input  logic [DWORD_W-1:0] mu_prod,
  input  logic               mu_uflow,
  output logic [DWORD_W-1:0] dv_numer,
  output logic [WORD_W-1:0]  dv_denom,
  input  logic [WORD_W-1:0]  dv_quot,
  input  logic [WORD_W-1:0]  dv_remain,
  input  logic               dv_uflow
);

  localparam int unsigned MaxAm  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int unsigned MaxLat = (MaxAm > DIV_LAT) ? MaxAm : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat) + 1;

  localparam logic [CntW-1:0] AddCnt = CntW'(ADD_LAT - 1);
  localparam logic [CntW-1:0] MulCnt = CntW'(MUL_LAT - 1);
  localparam logic [CntW-1:0] DivCnt = CntW'(DIV_LAT - 1);

  state_t              state_q, state_d;
  alu_op_t             op_q, op_d;
  logic [DWORD_W-1:0]  a_q, a_d;
  logic [WORD_W-1:0]   b_q, b_d;
  logic [WORD_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                ovf_q, ovf_d, uflow_q, uflow_d, dz_q, dz_d;

  logic                cnt_load, cnt_dec, cnt_zero;
  logic [CntW-1:0]     cnt_val;

  logic [WORD_W-1:0]   y_eff, sum_word;
  logic                add_ovf;
  logic [WORD_W-1:0]   cap_hi, cap_lo;
  logic                cap_ovf, cap_uflow;

  agc_alu_lat_cnt #(
    .Width (CntW)
  ) u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign y_eff   = (op_q == OP_SUB) ? ~b_q : b_q;
  assign add_ovf = (a_q[WORD_W-1] == y_eff[WORD_W-1]) && (as_sum[WORD_W-1] != a_q[WORD_W-1]);

`ifdef AGC_ALU_ZERO_NORM_EN
  assign sum_word = (as_sum == NEG_ZERO) ? POS_ZERO : as_sum;
`else
  assign sum_word = as_sum;
`endif

  // Unit outputs selected by the latched op; only sampled on the final WAIT edge.
  always_comb begin
    cap_hi    = POS_ZERO;
    cap_lo    = POS_ZERO;
    cap_ovf   = 1'b0;
    cap_uflow = 1'b0;
    unique case (op_q)
      OP_ADD, OP_SUB: begin
        cap_hi  = sum_word;
        cap_ovf = add_ovf;
      end
      OP_MULT: begin
        cap_hi    = mu_prod[DWORD_W-1:WORD_W];
        cap_lo    = mu_prod[WORD_W-1:0];
        cap_uflow = mu_uflow;
      end
      OP_DIV: begin
        cap_hi    = dv_quot;
        cap_lo    = dv_remain;
        cap_uflow = dv_uflow;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    ovf_d    = ovf_q;
    uflow_d  = uflow_q;
    dz_d     = dz_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d = bus.req_op;
          a_d  = bus.req_a;
          b_d  = bus.req_b;
          if ((bus.req_op == OP_DIV) && is_zero(bus.req_b)) begin
            state_d = DONE;
            hi_d    = POS_ZERO;
            lo_d    = POS_ZERO;
            ovf_d   = 1'b0;
            uflow_d = 1'b0;
            dz_d    = 1'b1;
          end else begin
            state_d  = WAIT;
            cnt_load = 1'b1;
            unique case (bus.req_op)
              OP_MULT: cnt_val = MulCnt;
              OP_DIV:  cnt_val = DivCnt;
              default: cnt_val = AddCnt;
            endcase
          end
        end
      end
      WAIT: begin
        if (cnt_zero) begin
          state_d = DONE;
          hi_d    = cap_hi;
          lo_d    = cap_lo;
          ovf_d   = cap_ovf;
          uflow_d = cap_uflow;
          dz_d    = 1'b0;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ovf_q   <= 1'b0;
      uflow_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ovf_q   <= ovf_d;
      uflow_q <= uflow_d;
      dz_q    <= dz_d;
    end
  end

  assign as_x     = a_q[WORD_W-1:0];
  assign as_y     = b_q;
  assign as_sub   = (op_q == OP_SUB);
  assign mu_x     = a_q[WORD_W-1:0];
  assign mu_y     = b_q;
  assign dv_numer = a_q;
  assign dv_denom = b_q;

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == DONE);
  assign bus.resp_hi    = hi_q;
  assign bus.resp_lo    = lo_q;
  assign bus.resp_ovf   = ovf_q;
  assign bus.resp_uflow = uflow_q;
  assign bus.resp_dz    = dz_q;

endmodule

// File: tb/tb_agc_alu_seq.sv
// Directed bench for agc_alu_seq with behavioural arithmetic units attached
// and a queue of expected responses.
module tb_agc_alu_seq;
  import agc_alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  agc_alu_seq_if bus ();

  logic [14:0] as_x, as_y, as_sum, mu_x, mu_y, dv_denom, dv_quot, dv_remain;
  logic        as_sub, mu_uflow, dv_uflow;
  logic [29:0] mu_prod, dv_numer, dq, dr;

  agc_alu_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .as_x      (as_x),
    .as_y      (as_y),
    .as_sub    (as_sub),
    .as_sum    (as_sum),
    .mu_x      (mu_x),
    .mu_y      (mu_y),
    .mu_prod   (mu_prod),
    .mu_uflow  (mu_uflow),
    .dv_numer  (dv_numer),
    .dv_denom  (dv_denom),
    .dv_quot   (dv_quot),
    .dv_remain (dv_remain),
    .dv_uflow  (dv_uflow)
  );

  // Behavioural ones-complement units.
  function automatic logic [14:0] oc_add(input logic [14:0] x, input logic [14:0] y);
    logic [15:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[14:0] + {14'b0, s[15]};
  endfunction

  function automatic logic [29:0] oc_mul(input logic [14:0] x, input logic [14:0] y);
    logic [13:0] mx, my;
    logic [27:0] p;
    logic [14:0] hi, lo;
    mx = x[14] ? ~x[13:0] : x[13:0];
    my = y[14] ? ~y[13:0] : y[13:0];
    p  = {14'b0, mx} * {14'b0, my};
    hi = {1'b0, p[27:14]};
    lo = {1'b0, p[13:0]};
    if (x[14] ^ y[14]) begin
      hi = ~hi;
      lo = ~lo;
    end
    return {hi, lo};
  endfunction

  assign as_sum  = oc_add(as_x, as_sub ? ~as_y : as_y);
  assign mu_prod = oc_mul(mu_x, mu_y);

  always_comb begin
    dq = '0;
    dr = '0;
    if (dv_denom != 15'h0000) begin
      dq = dv_numer / {15'b0, dv_denom};
      dr = dv_numer % {15'b0, dv_denom};
    end
  end
  assign dv_quot   = dq[29:15];
  assign dv_remain = dr[14:0];

  typedef struct {
    logic [14:0] hi;
    logic [14:0] lo;
    logic        ovf;
    logic        uflow;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one request, returning at the first sample point after acceptance.
  task automatic issue(input string tag, input alu_op_t op, input logic [29:0] a,
                       input logic [14:0] b, input logic [14:0] hi, input logic [14:0] lo,
                       input logic ovf, input logic uflow, input logic dz, input int lat);
    exp_t e;
    @(negedge clk);
    check({tag, ".req_ready"}, {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    e.hi = hi; e.lo = lo; e.ovf = ovf; e.uflow = uflow; e.dz = dz; e.lat = lat;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic collect(input string tag);
    exp_t e;
    int   lat;
    lat = 0;
    while (!bus.resp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    check({tag, ".latency"}, lat, e.lat);
    check({tag, ".hi"}, {17'b0, bus.resp_hi}, {17'b0, e.hi});
    check({tag, ".lo"}, {17'b0, bus.resp_lo}, {17'b0, e.lo});
    check({tag, ".ovf"}, {31'b0, bus.resp_ovf}, {31'b0, e.ovf});
    check({tag, ".uflow"}, {31'b0, bus.resp_uflow}, {31'b0, e.uflow});
    check({tag, ".dz"}, {31'b0, bus.resp_dz}, {31'b0, e.dz});
  endtask

  task automatic release_resp(input string tag);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check({tag, ".rel_valid"}, {31'b0, bus.resp_valid}, 32'd0);
    check({tag, ".rel_ready"}, {31'b0, bus.req_ready}, 32'd1);
  endtask

  task automatic run(input string tag, input alu_op_t op, input logic [29:0] a,
                     input logic [14:0] b, input logic [14:0] hi, input logic [14:0] lo,
                     input logic ovf, input logic uflow, input logic dz, input int lat);
    issue(tag, op, a, b, hi, lo, ovf, uflow, dz, lat);
    collect(tag);
    release_resp(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, observed hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [14:0] sub_zero;
    bit          seen;
`ifdef AGC_ALU_ZERO_NORM_EN
    sub_zero = 15'h0000;
`else
    sub_zero = 15'h7FFF;
`endif
    bus.req_valid  = 1'b0;
    bus.req_op     = OP_ADD;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    mu_uflow       = 1'b0;
    dv_uflow       = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst.resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst.resp_hi", {17'b0, bus.resp_hi}, 32'd0);
    rst_n = 1'b1;

    // Both uflow sources high: ADD must not pass either through
    mu_uflow = 1'b1;
    dv_uflow = 1'b1;
    run("add_5_3", OP_ADD, 30'h5, 15'h0003, 15'h0008, 15'h0, 1'b0, 1'b0, 1'b0, 1);
    mu_uflow = 1'b0;
    dv_uflow = 1'b0;
    run("add_ovf", OP_ADD, 30'h3FFF, 15'h0001, 15'h4000, 15'h0, 1'b1, 1'b0, 1'b0, 1);
    run("sub_3_3", OP_SUB, 30'h3, 15'h0003, sub_zero, 15'h0, 1'b0, 1'b0, 1'b0, 1);
    run("sub_ovf", OP_SUB, 30'h4000, 15'h0001, 15'h3FFF, 15'h0, 1'b1, 1'b0, 1'b0, 1);
    run("mul_m1_2", OP_MULT, 30'h7FFE, 15'h0002, 15'h7FFF, 15'h7FFD, 1'b0, 1'b0, 1'b0, 2);
    run("mul_hi", OP_MULT, 30'h1000, 15'h0010, 15'h0004, 15'h0000, 1'b0, 1'b0, 1'b0, 2);
    mu_uflow = 1'b1;
    run("mul_uflow", OP_MULT, 30'h3, 15'h0004, 15'h0000, 15'h000C, 1'b0, 1'b1, 1'b0, 2);
    mu_uflow = 1'b0;

    dv_uflow = 1'b1;
    run("div_negz", OP_DIV, 30'h5, 15'h7FFF, 15'h0, 15'h0, 1'b0, 1'b0, 1'b1, 0);
    run("div_posz", OP_DIV, 30'h5, 15'h0000, 15'h0, 15'h0, 1'b0, 1'b0, 1'b1, 0);
    run("div_7_2", OP_DIV, 30'd7, 15'h0002, 15'h0000, 15'h0001, 1'b0, 1'b1, 1'b0, 3);
    dv_uflow = 1'b0;
    run("div_big", OP_DIV, 30'h0010_0000, 15'h0002, 15'h0010, 15'h0000, 1'b0, 1'b0, 1'b0, 3);

    // Back-pressure: response must hold while resp_ready is low
    issue("hold", OP_MULT, 30'h7FFE, 15'h0002, 15'h7FFF, 15'h7FFD, 1'b0, 1'b0, 1'b0, 2);
    collect("hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold.resp_valid", {31'b0, bus.resp_valid}, 32'd1);
      check("hold.req_ready", {31'b0, bus.req_ready}, 32'd0);
      check("hold.hi", {17'b0, bus.resp_hi}, 32'h7FFF);
      check("hold.lo", {17'b0, bus.resp_lo}, 32'h7FFD);
    end
    release_resp("hold");

    // Reset during WAIT discards the in-flight DIV
    issue("rst_wait", OP_DIV, 30'd7, 15'h0002, 15'h0, 15'h0, 1'b0, 1'b0, 1'b0, 3);
    sb.delete();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_wait.req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_wait.resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_wait.resp_hi", {17'b0, bus.resp_hi}, 32'd0);
    check("rst_wait.resp_lo", {17'b0, bus.resp_lo}, 32'd0);
    check("rst_wait.flags", {29'b0, bus.resp_ovf, bus.resp_uflow, bus.resp_dz}, 32'd0);
    check("rst_wait.as", {1'b0, as_x, as_y, as_sub}, 32'd0);
    check("rst_wait.mu", {2'b0, mu_x, mu_y}, 32'd0);
    check("rst_wait.dv", {2'b0, dv_numer}, 32'd0);
    check("rst_wait.dv_denom", {17'b0, dv_denom}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1'b1;
    end
    check("rst_wait.no_resp", {31'b0, seen}, 32'd0);

    run("post_rst", OP_ADD, 30'h5, 15'h0003, 15'h0008, 15'h0, 1'b0, 1'b0, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
